// File: rtl/uart_alu_if.sv
// Command/response stage: pops A, B, opcode from the RX FIFO, drives the ALU, pushes the result to the TX FIFO.
// Latency: TX push two cycles after the opcode pop; a full command takes at least 5 cycles.
// Backpressure: an empty RX FIFO stalls the operand fetch, and a full TX FIFO holds the result in S_SEND.
module uart_alu_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic               o_rx_rd,
    input  logic               i_tx_full,
    output logic               o_tx_wr,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result
);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] result_q, result_d;
    // Low during reset and for the first cycle after release, so no strobe
    // can fire before the surrounding FIFOs have come out of reset too.
    logic               run_q;
    logic               rx_rd;
    logic               tx_wr;

    // Next-state decode: each fetch state consumes one byte when the RX FIFO has one.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        rx_rd    = 1'b0;
        tx_wr    = 1'b0;
        if (run_q) begin
            case (state_q)
                S_A: begin
                    if (!i_rx_empty) begin
                        rx_rd   = 1'b1;
                        a_d     = i_rx_data;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (!i_rx_empty) begin
                        rx_rd   = 1'b1;
                        b_d     = i_rx_data;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (!i_rx_empty) begin
                        rx_rd   = 1'b1;
                        op_d    = i_rx_data[NB_OP-1:0];
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable for a full cycle; sample the result.
                    result_d = i_alu_result;
                    state_d  = S_SEND;
                end
                S_SEND: begin
                    if (!i_tx_full) begin
                        tx_wr   = 1'b1;
                        state_d = S_A;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    // State and datapath registers; reset clears the partial command immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            run_q    <= 1'b1;
        end
    end

    assign o_rx_rd   = rx_rd;
    assign o_tx_wr   = tx_wr;
    assign o_tx_data = result_q;
    assign o_alu_a   = a_q;
    assign o_alu_b   = b_q;
    assign o_alu_op  = op_q;

endmodule

// File: tb/tb_uart_alu_if.sv
module tb_uart_alu_if;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rx_empty;
    logic [7:0] i_rx_data;
    logic       o_rx_rd;
    logic       i_tx_full;
    logic       o_tx_wr;
    logic [7:0] o_tx_data;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] i_alu_result;

    int tests = 0;
    int fails = 0;

    // RX FIFO model (first-word-fall-through)
    logic [7:0] rx_mem [64];
    int         rx_wr = 0;
    int         rx_rdp = 0;

    // monitors
    int         cyc = 0;
    int         rd_cnt = 0;
    int         tx_cnt = 0;
    int         both_cnt = 0;
    int         rd_cyc [64];
    int         tx_cyc [16];
    logic [7:0] tx_log [16];

    uart_alu_if #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_empty   (i_rx_empty),
        .i_rx_data    (i_rx_data),
        .o_rx_rd      (o_rx_rd),
        .i_tx_full    (i_tx_full),
        .o_tx_wr      (o_tx_wr),
        .o_tx_data    (o_tx_data),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .i_alu_result (i_alu_result)
    );

    always #5 i_clk = ~i_clk;

    assign i_rx_empty = (rx_wr == rx_rdp);
    assign i_rx_data  = rx_mem[rx_rdp[5:0]];

    // ALU model: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR
    always_comb begin
        case (o_alu_op)
            6'h20:   i_alu_result = o_alu_a + o_alu_b;
            6'h22:   i_alu_result = o_alu_a - o_alu_b;
            6'h24:   i_alu_result = o_alu_a & o_alu_b;
            6'h25:   i_alu_result = o_alu_a | o_alu_b;
            default: i_alu_result = 8'h00;
        endcase
    end

    always @(posedge i_clk) begin
        if (o_rx_rd) begin
            rd_cyc[rd_cnt[5:0]] = cyc;
            rd_cnt = rd_cnt + 1;
            rx_rdp <= rx_rdp + 1;
        end
        if (o_tx_wr) begin
            tx_log[tx_cnt[3:0]] = o_tx_data;
            tx_cyc[tx_cnt[3:0]] = cyc;
            tx_cnt = tx_cnt + 1;
        end
        if (o_rx_rd && o_tx_wr) both_cnt = both_cnt + 1;
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[rx_wr[5:0]] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic wait_tx(input int n);
        int budget;
        budget = 200;
        while (tx_cnt < n && budget > 0) begin
            @(negedge i_clk);
            budget--;
        end
        if (tx_cnt < n) begin
            tests++;
            fails++;
            $error("FAIL wait_tx timeout: observed %0d writes expected %0d", tx_cnt, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    int rb;
    int tb0;
    int rel_cyc;

    initial begin
        i_reset   = 1'b1;
        i_tx_full = 1'b0;
        // ---- reset state, with data already waiting in the RX FIFO
        push(8'h05); push(8'h03); push(8'h20);
        idle(2);
        chk("rst_rx_rd", o_rx_rd, 0);
        chk("rst_tx_wr", o_tx_wr, 0);
        chk("rst_alu_a", o_alu_a, 0);
        chk("rst_alu_b", o_alu_b, 0);
        chk("rst_alu_op", o_alu_op, 0);
        chk("rst_tx_data", o_tx_data, 0);
        i_reset = 1'b0;
        #1;
        chk("post_rst_rx_rd", o_rx_rd, 0);

        // ---- test 1: 5 + 3 ADD, best-case latency
        wait_tx(1);
        idle(10);
        chk("t1_rd_cnt", rd_cnt, 3);
        chk("t1_tx_cnt", tx_cnt, 1);
        chk("t1_data", tx_log[0], 8'h08);
        chk("t1_latency", tx_cyc[0] - rd_cyc[2], 2);
        chk("t1_pop_spacing", rd_cyc[2] - rd_cyc[0], 2);

        // ---- test 2: F0 AND 0F with 10-cycle gaps
        rb = rd_cnt; tb0 = tx_cnt;
        push(8'hF0);
        idle(10);
        chk("t2_stall_b_rd", rd_cnt, rb + 1);
        push(8'h0F);
        idle(10);
        chk("t2_stall_op_rd", rd_cnt, rb + 2);
        chk("t2_no_early_tx", tx_cnt, tb0);
        push(8'h24);
        wait_tx(tb0 + 1);
        idle(8);
        chk("t2_tx_cnt", tx_cnt, tb0 + 1);
        chk("t2_data", tx_log[tb0[3:0]], 8'h00);
        chk("t2_alu_a_held", o_alu_a, 8'hF0);
        chk("t2_alu_b_held", o_alu_b, 8'h0F);

        // ---- test 3: 0A SUB 0C with TX full for 20 cycles
        rb = rd_cnt; tb0 = tx_cnt;
        i_tx_full = 1'b1;
        push(8'h0A); push(8'h0C); push(8'h22);
        idle(6);
        idle(20);
        chk("t3_full_no_wr", tx_cnt, tb0);
        chk("t3_full_tx_wr", o_tx_wr, 0);
        chk("t3_full_data", o_tx_data, 8'hFE);
        chk("t3_no_extra_pop", rd_cnt, rb + 3);
        i_tx_full = 1'b0;
        rel_cyc = cyc;
        wait_tx(tb0 + 1);
        idle(8);
        chk("t3_data", tx_log[tb0[3:0]], 8'hFE);
        chk("t3_wr_timing", tx_cyc[tb0[3:0]], rel_cyc);
        chk("t3_tx_cnt", tx_cnt, tb0 + 1);

        // ---- test 4: opcode upper bits discarded
        tb0 = tx_cnt;
        push(8'h05); push(8'h03); push(8'hE0);
        wait_tx(tb0 + 1);
        idle(2);
        chk("t4_alu_op", o_alu_op, 6'b100000);
        chk("t4_data", tx_log[tb0[3:0]], 8'h08);

        // ---- test 5: reset mid-transaction
        rb = rd_cnt; tb0 = tx_cnt;
        push(8'h11); push(8'h22);
        idle(5);
        chk("t5_partial_rd", rd_cnt, rb + 2);
        chk("t5_partial_b", o_alu_b, 8'h22);
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        #1;
        chk("t5_async_a", o_alu_a, 0);
        chk("t5_async_b", o_alu_b, 0);
        chk("t5_async_op", o_alu_op, 0);
        chk("t5_async_data", o_tx_data, 0);
        idle(3);
        i_reset = 1'b0;
        idle(4);
        chk("t5_no_wr", tx_cnt, tb0);
        push(8'h01); push(8'h01); push(8'h20);
        wait_tx(tb0 + 1);
        idle(10);
        chk("t5_data", tx_log[tb0[3:0]], 8'h02);
        chk("t5_tx_cnt", tx_cnt, tb0 + 1);
        chk("t5_alu_a", o_alu_a, 8'h01);

        // ---- test 6: two commands back-to-back
        tb0 = tx_cnt;
        push(8'h01); push(8'h02); push(8'h20);
        push(8'h07); push(8'h01); push(8'h22);
        wait_tx(tb0 + 2);
        idle(8);
        chk("t6_data0", tx_log[tb0[3:0]], 8'h03);
        chk("t6_data1", tx_log[(tb0 + 1) & 15], 8'h06);
        chk("t6_spacing", tx_cyc[(tb0 + 1) & 15] - tx_cyc[tb0[3:0]], 5);
        chk("t6_tx_cnt", tx_cnt, tb0 + 2);

        chk("never_both_strobes", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_alu_if.md
Name: uart_alu_if

Overview:
- Command/response stage between the UART receive FIFO and transmit FIFO inside the uart top.
- Pops three bytes from the RX FIFO in order: operand A, operand B, opcode.
- Presents A, B and opcode to the combinational ALU, captures the ALU result, and pushes it as one byte into the TX FIFO.
- Sits downstream of the RX FIFO, upstream of the TX FIFO. The testbench sees it as rx byte stream in, tx byte stream out.

Parameters:
- NB_DATA, 8, width of UART bytes, operands and result.
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_rx_empty  input  1  RX FIFO empty flag.
- i_rx_data  input  NB_DATA  RX FIFO head word; valid whenever i_rx_empty=0 (first-word-fall-through).
- o_rx_rd  output  1  RX FIFO pop strobe; pops the head on this clock edge.
- i_tx_full  input  1  TX FIFO full flag.
- o_tx_wr  output  1  TX FIFO push strobe.
- o_tx_data  output  NB_DATA  byte written to the TX FIFO when o_tx_wr=1.
- o_alu_a  output  NB_DATA  registered operand A to the ALU.
- o_alu_b  output  NB_DATA  registered operand B to the ALU.
- o_alu_op  output  NB_OP  registered opcode to the ALU.
- i_alu_result  input  NB_DATA  combinational ALU result.

Behaviour:
Reset:
- Reset is asynchronous and active-high. Assertion immediately forces state S_A.
- o_alu_a, o_alu_b, o_alu_op and the result register reset to 0.
- o_rx_rd and o_tx_wr are 0 during reset and in the first cycle after release.

FSM, one state per cycle unless it stalls:
- S_A: if i_rx_empty=0, assert o_rx_rd, load o_alu_a<=i_rx_data, go to S_B. Otherwise stay, o_rx_rd=0.
- S_B: same as S_A, but loads o_alu_b; go to S_OP.
- S_OP: same, but loads o_alu_op<=i_rx_data[NB_OP-1:0] (upper bits discarded); go to S_EXEC.
- S_EXEC: one cycle, no strobes. ALU inputs are now stable. Capture result_reg<=i_alu_result; go to S_SEND.
- S_SEND: o_tx_data=result_reg at all times in this state.
  - If i_tx_full=0, assert o_tx_wr for exactly one cycle and go to S_A.
  - If i_tx_full=1, hold with o_tx_wr=0 and o_tx_data stable until not full.

Strobes and outputs:
- o_rx_rd and o_tx_wr are Moore/Mealy decodes of the state and the FIFO flag. They are never asserted while the corresponding flag blocks them.
- o_rx_rd and o_tx_wr are never both 1 in the same cycle.
- o_tx_data outside S_SEND holds result_reg (don't-care to the FIFO).

Timing:
- Best-case latency: o_rx_rd of the opcode byte at cycle n, capture in S_EXEC at cycle n+1, o_tx_wr at cycle n+2.
- Minimum transaction length is 5 cycles, so at most one result byte per 5 clocks.
- Gaps in RX data (empty between bytes) only stall the FSM. Partial operands are retained indefinitely; there is no timeout.

Boundary conditions:
- o_alu_a/b/op keep the last values between transactions; they are only overwritten as each new byte is popped.
- A new operand A popped during the next transaction changes the ALU inputs only after the previous result has been captured.
- Reset mid-transaction discards the partial command. No write is issued, and the next byte popped is treated as operand A.
- Opcode interpretation belongs to the ALU; this block passes any NB_OP value through unchanged.

Test Plan:
- RX FIFO preloaded 0x05, 0x03, 0x20; ALU model ADD=0x20; TX never full: exactly three single-cycle o_rx_rd pulses; o_tx_wr one cycle with o_tx_data=0x08, two cycles after the third pop.
- Bytes 0xF0, 0x0F, 0x24 (AND) arriving with 10-cycle empty gaps: FSM stalls in S_B and S_OP with o_rx_rd=0; single write of 0x00; o_alu_a=0xF0 and o_alu_b=0x0F still held afterwards.
- 0x0A, 0x0C, 0x22 (SUB) with i_tx_full=1 for 20 cycles at S_SEND: o_tx_wr stays 0 and o_tx_data holds 0xFE; one write the cycle after i_tx_full falls; no extra RX pops meanwhile.
- Opcode byte 0xE0: o_alu_op=6'b100000 (upper bits dropped); result 0x08 for A=0x05, B=0x03.
- Pop 0x11 and 0x22, then assert i_reset for 3 cycles mid-clock: outputs go to 0 asynchronously; next bytes 0x01, 0x01, 0x20 produce exactly one write of 0x02.
- Six bytes back-to-back (two commands 0x01,0x02,0x20 and 0x07,0x01,0x22): writes 0x03 then 0x06, spaced exactly 5 cycles apart.
